spi_slave: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) responder, MSB first, 8-bit words, oversampled by the system clock. It is the peripheral end of the `spi_master` link in the PIM instruction simulation. It lets on-chip logic receive command bytes and return response bytes over the same SCLK/MOSI/MISO/CS_N pins. Frames can carry any number of back-to-back bytes while `cs_n` stays low.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 207 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, word width and a shift helper.
package spi_pkg;

   localparam int SPI_WORD_W = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

   // Shift a word left by one place, inserting a new bit at the LSB.
   function automatic logic [SPI_WORD_W-1:0] shift_in(input logic [SPI_WORD_W-1:0] word,
                                                      input logic                  bit_in);
      return {word[SPI_WORD_W-2:0], bit_in};
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with one extra flop
// on the synchronized level for rise/fall detection.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // Synchronizer chain plus the delayed copy used for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{RST_VAL}};
         prev_r <= RST_VAL;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign level = sync_r[STAGES-1];
   assign rise  = level & ~prev_r;
   assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit words, oversampled by clk.
// Receives command bytes on mosi and returns bytes from a one-entry
// holding register on miso; frames may carry any number of bytes.
module spi_slave import spi_pkg::*; #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_TX     = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs_n,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       busy
);

   // synchronized pins and edges
   logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
   logic mosi_lvl_s, mosi_rise_unused_s, mosi_fall_unused_s;
   logic cs_lvl_s, cs_rise_unused_s, cs_fall_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(mosi),
      .level(mosi_lvl_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(cs_n),
      .level(cs_lvl_s), .rise(cs_rise_unused_s), .fall(cs_fall_s)
   );

   spi_state_t            state_r, state_s;
   logic [2:0]            bit_cnt_r, bit_cnt_s;
   logic [SPI_WORD_W-1:0] rx_sh_r, rx_sh_s;
   logic [SPI_WORD_W-1:0] tx_sh_r, tx_sh_s;
   logic [SPI_WORD_W-1:0] hold_r, hold_s;
   logic                  hold_full_r, hold_full_s;
   // set when a new byte was loaded at a byte boundary: the next sclk fall
   // exposes its MSB instead of shifting
   logic                  pend_r, pend_s;
   logic                  miso_r, miso_s;
   logic [SPI_WORD_W-1:0] rx_data_r, rx_data_s;
   logic                  rx_valid_r, rx_valid_s;
   logic                  underrun_r, underrun_s;
   logic                  busy_r, miso_oe_r, tx_ready_r;
   logic                  load_s;
   logic [SPI_WORD_W-1:0] load_byte_s;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, shifter, counter and holding-register logic.
   always_comb begin
      state_s     = state_r;
      bit_cnt_s   = bit_cnt_r;
      rx_sh_s     = rx_sh_r;
      tx_sh_s     = tx_sh_r;
      pend_s      = pend_r;
      miso_s      = miso_r;
      rx_data_s   = rx_data_r;
      rx_valid_s  = 1'b0;
      underrun_s  = 1'b0;
      hold_s      = hold_r;
      hold_full_s = hold_full_r;
      load_s      = 1'b0;
      load_byte_s = IDLE_TX;

      case (state_r)
         IDLE: begin
            miso_s    = 1'b0;
            pend_s    = 1'b0;
            bit_cnt_s = 3'd0;
            if (cs_fall_s) begin
               state_s = SHIFT;
               load_s  = 1'b1;
               rx_sh_s = 8'h00;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            // deselect wins over a coincident sclk edge; partial bits are dropped
            if (cs_lvl_s) begin
               state_s   = IDLE;
               bit_cnt_s = 3'd0;
               rx_sh_s   = 8'h00;
               pend_s    = 1'b0;
               miso_s    = 1'b0;
            end else if (sclk_rise_s) begin
               rx_sh_s   = shift_in(rx_sh_r, mosi_lvl_s);
               bit_cnt_s = bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  rx_data_s  = rx_sh_s;
                  rx_valid_s = 1'b1;
                  load_s     = 1'b1;
                  pend_s     = 1'b1;
               end else begin
                  rx_valid_s = 1'b0;
               end
            end else if (sclk_fall_s) begin
               if (pend_r) begin
                  miso_s = tx_sh_r[7];
                  pend_s = 1'b0;
               end else begin
                  tx_sh_s = shift_in(tx_sh_r, 1'b0);
                  miso_s  = tx_sh_r[6];
               end
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
            miso_s  = 1'b0;
         end
      endcase

      // shifter load: held byte first, then same-cycle bypass, else idle filler
      if (load_s) begin
         if (hold_full_r) begin
            load_byte_s = hold_r;
            hold_full_s = 1'b0;
         end else if (tx_valid) begin
            load_byte_s = tx_data;
         end else begin
            load_byte_s = IDLE_TX;
            underrun_s  = 1'b1;
         end
         tx_sh_s = load_byte_s;
         if (state_r == IDLE) begin
            miso_s = load_byte_s[7];
         end else begin
            pend_s = 1'b1;
         end
      end else begin
         load_byte_s = IDLE_TX;
      end

      // holding register write, unless the offered byte was just bypassed
      if (tx_valid && tx_ready_r && !(load_s && !hold_full_r)) begin
         hold_s      = tx_data;
         hold_full_s = 1'b1;
      end else begin
         hold_s = hold_r;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= 3'd0;
         rx_sh_r     <= 8'h00;
         tx_sh_r     <= 8'h00;
         hold_r      <= 8'h00;
         hold_full_r <= 1'b0;
         pend_r      <= 1'b0;
         miso_r      <= 1'b0;
         rx_data_r   <= 8'h00;
         rx_valid_r  <= 1'b0;
         underrun_r  <= 1'b0;
         busy_r      <= 1'b0;
         miso_oe_r   <= 1'b0;
         tx_ready_r  <= 1'b1;
      end else begin
         bit_cnt_r   <= bit_cnt_s;
         rx_sh_r     <= rx_sh_s;
         tx_sh_r     <= tx_sh_s;
         hold_r      <= hold_s;
         hold_full_r <= hold_full_s;
         pend_r      <= pend_s;
         miso_r      <= miso_s;
         rx_data_r   <= rx_data_s;
         rx_valid_r  <= rx_valid_s;
         underrun_r  <= underrun_s;
         busy_r      <= (state_s == SHIFT);
         miso_oe_r   <= (state_s == SHIFT);
         tx_ready_r  <= ~hold_full_s;
      end
   end

   assign miso        = miso_r;
   assign miso_oe     = miso_oe_r;
   assign tx_ready    = tx_ready_r;
   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign tx_underrun = underrun_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: the stimulus pushes expected rx/tx bytes,
// monitors pop and compare when rx_valid pulses or a full MISO byte is seen.
module tb_spi_slave;

   localparam int         S       = 2;
   localparam logic [7:0] IDLE_TX = 8'h00;
   localparam int         HALF    = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;

   spi_slave #(.SYNC_STAGES(S), .IDLE_TX(IDLE_TX)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_underrun(tx_underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_rise = 0;
   int         unr_cnt = 0;
   int         exp_unr = 0;
   logic       prev_rv = 1'b0;
   logic       prev_unr = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   int         tbits = 0;
   logic [7:0] tsh = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // rx monitor: data, latency from 8th rise, single-cycle strobes
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected: got %0h expected no strobe", rx_data);
            end else begin
               chk("rx_data", rx_data, rx_q.pop_front());
               chk("rx_latency", cyc - last_rise, S + 1);
            end
            chk("rx_valid_width", prev_rv, 1'b0);
         end
         if (tx_underrun) begin
            unr_cnt <= unr_cnt + 1;
            chk("underrun_width", prev_unr, 1'b0);
         end
      end
      prev_rv  <= rx_valid;
      prev_unr <= tx_underrun;
   end

   // tx monitor: assemble MISO as the master samples it on each sclk rise
   always @(posedge sclk or posedge cs_n) begin : tx_mon
      logic [7:0] nxt;
      if (cs_n) begin
         tbits <= 0;
      end else begin
         nxt = {tsh[6:0], miso};
         tsh <= nxt;
         if (tbits == 7) begin
            tbits <= 0;
            if (tx_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL tx_unexpected: got %0h expected nothing", nxt);
            end else begin
               chk("tx_byte", nxt, tx_q.pop_front());
            end
         end else begin
            tbits <= tbits + 1;
         end
      end
   end

   task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         repeat (half) @(negedge clk);
         sclk = 1'b1;
         if (i == 0) last_rise = cyc;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] mo, input logic [7:0] exp_tx, input int half);
      rx_q.push_back(mo);
      tx_q.push_back(exp_tx);
      spi_bits(mo, 8, half);
   endtask

   task automatic frame_start(input int half);
      cs_n = 1'b0;
      repeat (2 * half) @(negedge clk);
   endtask

   task automatic frame_end(input int half);
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
      repeat (2 * half) @(negedge clk);
   endtask

   task automatic offer(input logic [7:0] d);
      int n;
      n = 0;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("offer_ready", tx_ready, 1'b1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] mr[16];
      logic [7:0] mt[16];

      // reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_miso", miso, 1'b0);
      chk("rst_miso_oe", miso_oe, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_underrun", tx_underrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b1);

      // single byte: preloaded A5 out, 3C in; the end-of-byte reload underruns
      offer(8'hA5);
      chk("t1_ready_low", tx_ready, 1'b0);
      frame_start(HALF);
      chk("t1_busy", busy, 1'b1);
      chk("t1_oe", miso_oe, 1'b1);
      send(8'h3C, 8'hA5, HALF);
      frame_end(HALF);
      exp_unr += 1;
      chk("t1_busy_low", busy, 1'b0);
      chk("t1_ready_high", tx_ready, 1'b1);
      chk("t1_underruns", unr_cnt, exp_unr);

      // back-to-back: 11 held, 22 offered in byte 1, byte 3 underruns,
      // 33 offered in byte 3 keeps the final reload from underrunning
      offer(8'h11);
      frame_start(HALF);
      fork
         begin
            send(8'hDE, 8'h11, HALF);
            send(8'hAD, 8'h22, HALF);
            send(8'hBE, 8'h00, HALF);
         end
         begin
            repeat (300) @(negedge clk);
            offer(8'h22);
            repeat (1700) @(negedge clk);
            offer(8'h33);
         end
      join
      frame_end(HALF);
      exp_unr += 1;
      chk("t2_underruns", unr_cnt, exp_unr);

      // bypass: tx_valid high exactly on the cs_fall load cycle
      chk("t3_ready_pre", tx_ready, 1'b1);
      cs_n = 1'b0;
      repeat (S) @(negedge clk);
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      chk("t3_ready_a", tx_ready, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t3_ready_b", tx_ready, 1'b1);
      repeat (2 * HALF - S - 1) @(negedge clk);
      chk("t3_ready_c", tx_ready, 1'b1);
      send(8'hC3, 8'h5A, HALF);
      frame_end(HALF);
      exp_unr += 1;
      chk("t3_underruns", unr_cnt, exp_unr);

      // abort after 5 bits, then a full frame of 81
      frame_start(HALF);
      spi_bits(8'hFF, 5, HALF);
      chk("t4_busy_mid", busy, 1'b1);
      cs_n = 1'b1;
      repeat (S + 2) @(negedge clk);
      chk("t4_busy_low", busy, 1'b0);
      chk("t4_oe_low", miso_oe, 1'b0);
      chk("t4_rx_data_kept", rx_data, 8'hC3);
      repeat (HALF) @(negedge clk);
      frame_start(HALF);
      send(8'h81, IDLE_TX, HALF);
      frame_end(HALF);
      exp_unr += 3;
      chk("t4_underruns", unr_cnt, exp_unr);

      // reset mid-byte after 3 bits
      frame_start(HALF);
      spi_bits(8'h0F, 3, HALF);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_miso", miso, 1'b0);
      chk("t5_oe", miso_oe, 1'b0);
      chk("t5_rx_data", rx_data, 8'h00);
      chk("t5_rx_valid", rx_valid, 1'b0);
      chk("t5_underrun", tx_underrun, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_ready", tx_ready, 1'b1);
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_busy_after", busy, 1'b0);
      frame_start(HALF);
      send(8'hF0, IDLE_TX, HALF);
      frame_end(HALF);
      exp_unr += 3;
      chk("t5_underruns", unr_cnt, exp_unr);

      // minimum rate: 16 random bytes each way, feeder keeps the holding register full
      for (int i = 0; i < 16; i++) begin
         mr[i] = 8'($urandom_range(0, 255));
         mt[i] = 8'($urandom_range(0, 255));
      end
      offer(mt[0]);
      fork
         begin
            frame_start(S + 2);
            for (int i = 0; i < 16; i++) send(mr[i], mt[i], S + 2);
            frame_end(S + 2);
         end
         begin
            for (int j = 1; j < 16; j++) offer(mt[j]);
         end
      join
      exp_unr += 1;
      repeat (20) @(negedge clk);
      chk("t6_underruns", unr_cnt, exp_unr);
      chk("rx_queue_drained", rx_q.size(), 0);
      chk("tx_queue_drained", tx_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
